// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM state encodings.
package counter_seq_ctrl_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_STEP = 3'd3,
      ST_HALT = 3'd4
   } state_t;

endpackage

// File: rtl/key_event.sv
// Turns a raw active-low pushbutton into a single registered press pulse.
// Two synchronizer flops, one history flop, falling-edge detect.
module key_event (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic key_n,
   output logic press
);

   logic sync_0;
   logic sync_1;
   logic hist;

   // Chain presets to "released" so reset release never looks like a press.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync_0 <= 1'b1;
         sync_1 <= 1'b1;
         hist   <= 1'b1;
         press  <= 1'b0;
      end else begin
         sync_0 <= key_n;
         sync_1 <= sync_0;
         hist   <= sync_1;
         press  <= hist & ~sync_1;
      end
   end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the loadable up/down counter: converts key presses into
// single-cycle load / count strobes with load, step, free-run and halt modes.
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int W           = 3,
   parameter int BASE_DIV    = 2**22,
   parameter bit STOP_AT_END = 1'b1
) (
   input  logic         CLOCK_50,
   input  logic         reset,
   input  logic         key_load_n,
   input  logic         key_step_n,
   input  logic         key_run_n,
   input  logic         dir_up,
   input  logic [1:0]   rate_sel,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] cnt_q,
   output logic         cnt_load,
   output logic [W-1:0] cnt_load_d,
   output logic         cnt_en,
   output logic         cnt_up,
   output logic [2:0]   state,
   output logic         at_end
);

   localparam int PW = $clog2(BASE_DIV) + 3;

   state_t        state_q;
   state_t        state_d;
   logic          ev_load;
   logic          ev_step;
   logic          ev_run;
   logic [PW-1:0] presc;
   logic [PW-1:0] presc_lim;
   logic          tick;
   logic          halt_due;

   key_event u_key_load (.CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_load_n), .press(ev_load));
   key_event u_key_step (.CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_step_n), .press(ev_step));
   key_event u_key_run  (.CLOCK_50(CLOCK_50), .reset(reset), .key_n(key_run_n),  .press(ev_run));

   // ">=" rather than "==" so a shortened period fires at once instead of wrapping.
   assign presc_lim = PW'((BASE_DIV << rate_sel) - 1);
   assign tick      = (presc >= presc_lim);
   assign halt_due  = STOP_AT_END && at_end;
   assign state     = state_q;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (ev_load)      state_d = ST_LOAD;
            else if (ev_run)  state_d = ST_RUN;
            else if (ev_step) state_d = ST_STEP;
         end
         ST_LOAD: state_d = ST_IDLE;
         ST_STEP: state_d = ST_IDLE;
         ST_RUN: begin
            if (ev_load)               state_d = ST_LOAD;
            else if (ev_run)           state_d = ST_IDLE;
            else if (tick && halt_due) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (ev_load)     state_d = ST_LOAD;
            else if (ev_run) state_d = ST_RUN;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cnt_load = 1'b0;
      cnt_en   = 1'b0;
      case (state_q)
         ST_LOAD: cnt_load = 1'b1;
         ST_STEP: cnt_en   = 1'b1;
         ST_RUN:  cnt_en   = tick && !halt_due;
         default: ;
      endcase
   end

   // Prescaler only advances while staying in RUN, so every entry starts a fresh period.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         presc      <= '0;
         cnt_load_d <= '0;
         cnt_up     <= 1'b1;
         at_end     <= 1'b0;
      end else begin
         if (state_d != ST_RUN || state_q != ST_RUN || tick) begin
            presc <= '0;
         end else begin
            presc <= presc + 1'b1;
         end
         if (state_d == ST_LOAD) begin
            cnt_load_d <= load_val;
         end
         cnt_up <= dir_up;
         at_end <= cnt_up ? (&cnt_q) : ~(|cnt_q);
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl (W=3, BASE_DIV=4, STOP_AT_END=1):
// stimulus predicts strobe timing/value, a negedge monitor pops and compares.
module tb_counter_seq_ctrl;

   typedef struct {
      bit         is_load;
      int         cyc;
      logic [2:0] val;
   } exp_t;

   logic       CLOCK_50;
   logic       reset;
   logic       key_load_n;
   logic       key_step_n;
   logic       key_run_n;
   logic       dir_up;
   logic [1:0] rate_sel;
   logic [2:0] load_val;
   logic [2:0] cnt_q;
   logic       cnt_load;
   logic [2:0] cnt_load_d;
   logic       cnt_en;
   logic       cnt_up;
   logic [2:0] state;
   logic       at_end;

   exp_t sb[$];
   int   cyc         = 0;
   int   vectors     = 0;
   int   miscompares = 0;
   int   mv          = 0;

   counter_seq_ctrl #(.W(3), .BASE_DIV(4), .STOP_AT_END(1'b1)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset),
      .key_load_n(key_load_n), .key_step_n(key_step_n), .key_run_n(key_run_n),
      .dir_up(dir_up), .rate_sel(rate_sel), .load_val(load_val), .cnt_q(cnt_q),
      .cnt_load(cnt_load), .cnt_load_d(cnt_load_d), .cnt_en(cnt_en),
      .cnt_up(cnt_up), .state(state), .at_end(at_end)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   // Stand-in for the counter datapath on the board.
   always @(posedge CLOCK_50) begin
      if (reset)         cnt_q <= 3'd0;
      else if (cnt_load) cnt_q <= cnt_load_d;
      else if (cnt_en)   cnt_q <= cnt_up ? 3'(cnt_q + 3'd1) : 3'(cnt_q - 3'd1);
   end

   always @(negedge CLOCK_50) begin
      exp_t       e;
      logic [2:0] got;
      if (cnt_load && cnt_en) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL both_strobes @%0d: cnt_load=1 cnt_en=1, expected at most one", cyc);
      end else if (cnt_load || cnt_en) begin
         vectors++;
         got = cnt_load ? cnt_load_d : {2'b00, cnt_up};
         if (sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL unexpected_strobe @%0d: got load=%0b val=%0d, expected no strobe",
                     cyc, cnt_load, got);
         end else begin
            e = sb.pop_front();
            if (e.is_load != cnt_load || e.cyc != cyc || e.val != got) begin
               miscompares++;
               $display("[TB] FAIL strobe @%0d: got load=%0b val=%0d, expected load=%0b val=%0d at cycle %0d",
                        cyc, cnt_load, got, e.is_load, e.val, e.cyc);
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("[TB] FAIL %s @%0d: got %0d, expected %0d", name, cyc, got, exp);
      end
   endtask

   task automatic waitUntil(input int c);
      while (cyc < c) @(negedge CLOCK_50);
   endtask

   // Called on a negedge: press the chosen keys for hold cycles, then release.
   task automatic applyStimulus(input logic l, input logic s, input logic r, input int hold);
      key_load_n = ~l;
      key_step_n = ~s;
      key_run_n  = ~r;
      repeat (hold) @(negedge CLOCK_50);
      key_load_n = 1'b1;
      key_step_n = 1'b1;
      key_run_n  = 1'b1;
   endtask

   task automatic doLoad(input logic [2:0] v, input int hold, output int n);
      n        = cyc;
      load_val = v;
      sb.push_back('{is_load: 1'b1, cyc: n + 4, val: v});
      applyStimulus(1'b1, 1'b0, 1'b0, hold);
      mv = int'(v);
      repeat (6) @(negedge CLOCK_50);
   endtask

   task automatic doStep(input logic up, input int hold);
      dir_up = up;
      sb.push_back('{is_load: 1'b0, cyc: cyc + 4, val: {2'b00, up}});
      applyStimulus(1'b0, 1'b1, 1'b0, hold);
      mv = up ? (mv + 1) % 8 : (mv + 7) % 8;
      repeat (6) @(negedge CLOCK_50);
   endtask

   // Predicts RUN ticks: one every L cycles after entry; halts instead of
   // pulsing when the counter already sits at its terminal value.
   task automatic modelRun(input int entry, input int L, input int stopCyc, input logic up,
                           output int haltCyc);
      int t;
      haltCyc = -1;
      for (int k = 1; k < 1000; k++) begin
         t = entry + k * L - 1;
         if (t > stopCyc) break;
         if (mv == (up ? 7 : 0)) begin
            haltCyc = t + 1;
            break;
         end
         sb.push_back('{is_load: 1'b0, cyc: t, val: {2'b00, up}});
         mv = up ? (mv + 1) % 8 : (mv + 7) % 8;
      end
   endtask

   initial begin
      int n;
      int e;
      int p;
      int h;
      int lp;
      logic up;
      reset      = 1'b1;
      key_load_n = 1'b1;
      key_step_n = 1'b1;
      key_run_n  = 1'b1;
      dir_up     = 1'b1;
      rate_sel   = 2'd0;
      load_val   = 3'd0;

      repeat (3) @(negedge CLOCK_50);
      checkOutput("reset_state", int'(state), 0);
      checkOutput("reset_cnt_load", int'(cnt_load), 0);
      checkOutput("reset_cnt_en", int'(cnt_en), 0);
      checkOutput("reset_cnt_up", int'(cnt_up), 1);
      checkOutput("reset_cnt_load_d", int'(cnt_load_d), 0);
      checkOutput("reset_at_end", int'(at_end), 0);
      reset = 1'b0;
      repeat (10) @(negedge CLOCK_50);

      $display("[TB] load with long hold");
      doLoad(3'd5, 6, n);
      checkOutput("load_returns_idle", int'(state), 0);
      for (int i = 0; i < 3; i++) doLoad(3'($urandom_range(0, 7)), $urandom_range(1, 8), n);

      $display("[TB] single steps");
      doStep(1'b0, 20);
      repeat (16) @(negedge CLOCK_50);
      for (int i = 0; i < 4; i++) doStep(1'($urandom_range(0, 1)), $urandom_range(1, 5));

      $display("[TB] run at rate_sel=1 then pause");
      doLoad(3'd2, 1, n);
      dir_up   = 1'b1;
      rate_sel = 2'd1;
      repeat (3) @(negedge CLOCK_50);
      n = cyc;
      e = n + 4;
      p = e + 3 * 8 + 2;
      modelRun(e, 8, p + 3, 1'b1, h);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitUntil(e + 3);
      applyStimulus(1'b0, 1'b1, 1'b0, 2);
      waitUntil(p);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitUntil(p + 5);
      checkOutput("pause_state", int'(state), 0);
      repeat (30) @(negedge CLOCK_50);

      $display("[TB] randomized run segments");
      for (int i = 0; i < 6; i++) begin
         up = 1'($urandom_range(0, 1));
         dir_up   = up;
         rate_sel = 2'($urandom_range(0, 2));
         doLoad(3'($urandom_range(0, 7)), $urandom_range(1, 3), n);
         lp = 4 << rate_sel;
         n = cyc;
         e = n + 4;
         p = e + $urandom_range(1, 6) * lp + $urandom_range(0, lp - 1);
         modelRun(e, lp, p + 3, up, h);
         applyStimulus(1'b0, 1'b0, 1'b1, 1);
         waitUntil(p);
         doLoad(3'($urandom_range(0, 7)), 1, n);
         repeat (4) @(negedge CLOCK_50);
      end

      $display("[TB] run into terminal count");
      dir_up   = 1'b1;
      rate_sel = 2'd0;
      doLoad(3'd5, 2, n);
      n = cyc;
      e = n + 4;
      modelRun(e, 4, e + 100, 1'b1, h);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitUntil(h - 1);
      checkOutput("run_before_halt", int'(state), 2);
      @(negedge CLOCK_50);
      checkOutput("halt_state", int'(state), 4);
      checkOutput("halt_at_end", int'(at_end), 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 2);
      repeat (8) @(negedge CLOCK_50);
      checkOutput("halt_ignores_step", int'(state), 4);
      n = cyc;
      e = n + 4;
      modelRun(e, 4, e + 100, 1'b1, h);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitUntil(h - 1);
      checkOutput("rerun_from_halt", int'(state), 2);
      @(negedge CLOCK_50);
      checkOutput("rehalt_state", int'(state), 4);
      repeat (4) @(negedge CLOCK_50);
      n = cyc;
      load_val = 3'd3;
      sb.push_back('{is_load: 1'b1, cyc: n + 4, val: 3'd3});
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      mv = 3;
      waitUntil(n + 4);
      checkOutput("halt_to_load", int'(state), 1);
      @(negedge CLOCK_50);
      checkOutput("load_to_idle", int'(state), 0);
      repeat (6) @(negedge CLOCK_50);

      $display("[TB] simultaneous load and step");
      load_val = 3'd6;
      sb.push_back('{is_load: 1'b1, cyc: cyc + 4, val: 3'd6});
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      mv = 6;
      repeat (10) @(negedge CLOCK_50);

      $display("[TB] reset while running");
      dir_up   = 1'b1;
      rate_sel = 2'd2;
      n = cyc;
      e = n + 4;
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      waitUntil(e + 14);
      checkOutput("running_before_reset", int'(state), 2);
      reset = 1'b1;
      @(negedge CLOCK_50);
      checkOutput("reset_mid_run_state", int'(state), 0);
      checkOutput("reset_mid_run_cnt_en", int'(cnt_en), 0);
      checkOutput("reset_mid_run_cnt_up", int'(cnt_up), 1);
      checkOutput("reset_mid_run_load_d", int'(cnt_load_d), 0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      mv = 0;
      repeat (12) @(negedge CLOCK_50);

      checkOutput("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
